// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, default geometry.
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-wide memory port of the load/store unit.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_r;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Requester side; it also hosts the memory that answers mem_rdata.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_r, mem_w, mem_addr, mem_wdata
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_r, mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Little-endian lane helper: inserts store data into a word, or extracts and extends load data.
module byte_lane
  import mem_pkg::*;
#(
  parameter bit EXTRACT = 1'b0
) (
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] result_o
);
  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = word_i[{addr_i, 3'b000} +: 8];
  assign lane16 = addr_i[1] ? word_i[31:16] : word_i[15:0];

  // Select insert or extract behaviour; EXTRACT is fixed per instance.
  always_comb begin
    // NOTE: result_o gets a value before any branch, so no path leaves it unassigned (no latch).
    result_o = word_i;
    if (EXTRACT) begin
      case (size_i)
        SZ_BYTE: result_o = {{24{lane8[7] & ~uns_i}}, lane8};
        SZ_HALF: result_o = {{16{lane16[15] & ~uns_i}}, lane16};
        default: result_o = word_i;
      endcase
    end else begin
      case (size_i)
        SZ_BYTE: result_o[{addr_i, 3'b000} +: 8]   = data_i[7:0];
        SZ_HALF: result_o[{addr_i[1], 4'b0000} +: 16] = data_i[15:0];
        default: result_o = data_i;
      endcase
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word accesses onto a word-only memory, with RMW for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic             clk,
  input logic             clr_n,
  mem_access_unit_if.slave bus
);
  state_e            state_q, state_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_W-1:0] req_idx;
  logic              req_err;
  logic [31:0]       store_merged;
  logic [31:0]       load_data;

  assign req_idx = bus.req_addr[ADDR_W+1:2];

  byte_lane #(.EXTRACT(1'b0)) u_store_lane (
    .word_i  (bus.mem_rdata),
    .data_i  (bus.req_wdata),
    .addr_i  (bus.req_addr[1:0]),
    .size_i  (bus.req_size),
    .uns_i   (1'b0),
    .result_o(store_merged)
  );

  byte_lane #(.EXTRACT(1'b1)) u_load_lane (
    .word_i  (bus.mem_rdata),
    .data_i  (32'h0),
    .addr_i  (bus.req_addr[1:0]),
    .size_i  (bus.req_size),
    .uns_i   (bus.req_unsigned),
    .result_o(load_data)
  );

  // Reject reserved size, misalignment and addresses beyond the memory.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SZ_HALF: req_err = bus.req_addr[0];
      SZ_WORD: req_err = |bus.req_addr[1:0];
      SZ_RSVD: req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|bus.req_addr[31:ADDR_W+2]) req_err = 1'b1;
  end

  // Next state, memory-port drive and response values for the coming cycle.
  always_comb begin
    state_d       = state_q;
    merge_d       = merge_q;
    addr_d        = addr_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = 32'h0;
    bus.mem_r     = 1'b0;
    bus.mem_w     = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    bus.req_ready = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!bus.req_we) begin
            bus.mem_r    = 1'b1;
            bus.mem_addr = req_idx;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = load_data;
          end else if (bus.req_size == SZ_WORD) begin
            bus.mem_w     = 1'b1;
            bus.mem_addr  = req_idx;
            bus.mem_wdata = bus.req_wdata;
            rsp_valid_d   = 1'b1;
          end else begin
            // Sub-word store: read now, write the merged word next cycle.
            bus.mem_r    = 1'b1;
            bus.mem_addr = req_idx;
            merge_d      = store_merged;
            addr_d       = req_idx;
            state_d      = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        bus.mem_w     = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = merge_q;
        rsp_valid_d   = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers; reset abandons any pending RMW write.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      merge_q     <= 32'h0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      merge_q     <= merge_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;
  localparam int AW        = 10;
  localparam int MEM_WORDS = 1 << AW;
  localparam int MEM_BYTES = MEM_WORDS * 4;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_errors;
  int   wr_count;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory answering the unit's port.
  assign bus.mem_rdata = bus.mem_r ? mem[bus.mem_addr] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_w) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_count          <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Reference: byte-addressed memory, arithmetic sign extension.
  task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata);
    int     n;
    longint val;
    n     = 1 << size;
    err   = (size == 2'd3) || (addr % n != 0) || (addr >= MEM_BYTES);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr+i] = wdata[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val = val | (longint'(ref_mem[addr+i]) << (8*i));
        if (!uns && n < 4 && val[8*n-1]) val = val - (longint'(1) << (8*n));
        rdata = val[31:0];
      end
    end
  endtask

  task automatic set_req(input logic valid, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = valid;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // One complete access, entered and left at posedge+1 with the unit idle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got_err, output logic [31:0] got_rdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rw;
    bit          sub_st;
    model_access(we, size, uns, addr, wdata, exp_err, exp_rdata);
    sub_st = we && size != 2'd2 && !exp_err;
    if (exp_err)                exp_rw = 2'b00;
    else if (!we || sub_st)     exp_rw = 2'b10;
    else                        exp_rw = 2'b01;
    set_req(1'b1, we, size, uns, addr, wdata);
    #1;
    check("accept_ready", bus.req_ready, 1'b1);
    check("accept_rw", {bus.mem_r, bus.mem_w}, exp_rw);
    if (!exp_err) check("accept_addr", bus.mem_addr, addr[AW+1:2]);
    if (exp_rw == 2'b01) check("accept_wdata", bus.mem_wdata, wdata);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (sub_st) begin
      check("rmw_ready", bus.req_ready, 1'b0);
      check("rmw_rw", {bus.mem_r, bus.mem_w}, 2'b01);
      check("rmw_addr", bus.mem_addr, addr[AW+1:2]);
      check("rmw_wdata", bus.mem_wdata, ref_word(int'(addr[AW+1:2])));
      check("rmw_rsp_quiet", bus.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_err", bus.rsp_err, exp_err);
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    got_err   = bus.rsp_err;
    got_rdata = bus.rsp_rdata;
  endtask

  initial begin
    logic        e;
    logic [31:0] d, e_rd0, e_rd2, orig8;
    logic        e_er;
    int          wr0, mism;
    n_checks = 0;
    n_errors = 0;
    wr_count = 0;
    clr_n    = 1'b0;
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int w = 0; w < MEM_WORDS; w++) mem[w] <= $urandom;
    #1;
    for (int w = 0; w < MEM_WORDS; w++)
      for (int i = 0; i < 4; i++) ref_mem[4*w+i] = mem[w][8*i +: 8];

    // Reset state.
    #2;
    check("rst_valid", bus.rsp_valid, 1'b0);
    check("rst_err", bus.rsp_err, 1'b0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_rw", {bus.mem_r, bus.mem_w}, 2'b00);
    #20 clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load.
    wr0 = wr_count;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, e, d);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e, d);
    check("sw_lw_data", d, 32'h12345678);
    check("sw_one_write", wr_count - wr0, 1);
    check("sw_word4", mem[4], 32'h12345678);

    // Byte RMW and extension.
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, e, d);
    check("sb_word4", mem[4], 32'h12AB5678);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, e, d);
    check("lb", d, 32'hFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, e, d);
    check("lbu", d, 32'h000000AB);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, e, d);
    check("lh_hi", d, 32'h000012AB);
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h00008001, e, d);
    check("sh_word4", mem[4], 32'h12AB8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, e, d);
    check("lh_neg", d, 32'hFFFF8001);

    // Error cases.
    wr0 = wr_count;
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, e, d);
    check("err_lh_odd", e, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEADBEEF, e, d);
    check("err_sw_mis", e, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, e, d);
    check("err_range", e, 1'b1);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555, e, d);
    check("err_rsvd", e, 1'b1);
    check("err_no_write", wr_count - wr0, 0);

    // Reset during the RMW cycle of sb @0x20.
    orig8 = mem[8];
    set_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 32'h000000C3);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("mid_rmw_w", bus.mem_w, 1'b1);
    clr_n = 1'b0;
    #1;
    check("rst_mem_w_drop", bus.mem_w, 1'b0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    check("rst_word8", mem[8], orig8);
    @(posedge clk);
    #1;
    check("post_rst_ready", bus.req_ready, 1'b1);

    // Back-to-back: lw, sw, lb on consecutive edges.
    model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_er, e_rd0);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    #1;
    check("b2b_ready0", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    model_access(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D, e_er, d);
    set_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D);
    check("b2b_ready1", bus.req_ready, 1'b1);
    check("b2b_rsp0_valid", bus.rsp_valid, 1'b1);
    check("b2b_rsp0_data", bus.rsp_rdata, e_rd0);
    @(posedge clk);
    #1;
    model_access(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, e_er, e_rd2);
    set_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h15, 32'h0);
    check("b2b_ready2", bus.req_ready, 1'b1);
    check("b2b_rsp1_valid", bus.rsp_valid, 1'b1);
    check("b2b_rsp1_data", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_rsp2_valid", bus.rsp_valid, 1'b1);
    check("b2b_rsp2_data", bus.rsp_rdata, e_rd2);
    check("b2b_lb_lit", bus.rsp_rdata, 32'hFFFFFFF0);
    @(posedge clk);
    #1;
    check("b2b_idle", bus.rsp_valid, 1'b0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      int          r;
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'd4088 + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, e, d);
    end

    // Whole-memory comparison against the model.
    mism = 0;
    for (int w = 0; w < MEM_WORDS; w++) if (mem[w] !== ref_word(w)) mism++;
    check("mem_sweep", mism, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the word-addressed data memory. It accepts byte, halfword and word accesses at byte addresses. It drives the memory's word-only read/write port and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or an error for misaligned or out-of-range addresses.

## Interface
- ADDR_W, 10: word-index width of the memory port; memory holds 2^ADDR_W words.

- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: access rejected, no memory effect
- mem_r  out  1  memory read enable
- mem_w  out  1  memory write enable, sampled by memory at posedge
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr while mem_r=1

## Operation
- States:
  - IDLE: accepts requests.
  - RMW: second cycle of a sub-word store.
- Acceptance: req_valid & req_ready at a posedge.
- Error checks (any one true gives an error):
  - req_size=11
  - size half and addr[0]≠0
  - size word and addr[1:0]≠0
  - req_addr[31:ADDR_W+2]≠0
- Error response: no mem_r/mem_w, stays IDLE, rsp_valid=1 and rsp_err=1 next cycle.
- Lanes are little-endian.
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
- Load, in IDLE with a valid request:
  - mem_r=1, mem_addr=addr[ADDR_W+1:2].
  - At acceptance, extract the lane, extend it, register it into rsp_rdata.
- Word store, in IDLE: mem_w=1, mem_wdata=req_wdata. Completes in one cycle.
- Sub-word store:
  - Acceptance cycle: mem_r=1. Register the read word with the new lane inserted into merge_q. Register the address into addr_q. Go to RMW.
  - RMW cycle: mem_w=1, mem_addr=addr_q, mem_wdata=merge_q, req_ready=0. Then return to IDLE.
- mem_r and mem_w are never both 1.
- When no access is being made: mem_r=0, mem_w=0, mem_addr=0, mem_wdata=0.
- Reset (asynchronous, any state):
  - state goes to IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0, merge_q=0, addr_q=0.
  - A pending RMW write is abandoned; mem_w drops immediately.

## Timing
- Memory-port outputs are combinational from state, the request inputs and the registers. Response outputs are registered.
- Latency from acceptance edge to rsp_valid:
  - load, word store, error: rsp_valid in the cycle after acceptance.
  - sub-word store: rsp_valid in the cycle after RMW, i.e. 2 cycles after acceptance.
- Throughput: one request per cycle back-to-back, except that a sub-word store blocks the next acceptance for 1 cycle.
- A load accepted in the cycle right after RMW sees the updated word, because the memory write lands at the RMW posedge.
- Inputs are ignored while req_ready=0. The requester holds req_* until acceptance.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum {ST_IDLE, ST_RMW}
  - default ADDR_W
- Sub-module byte_lane: purely combinational.
  - insert(word, data, addr[1:0], size) returns the merged word.
  - extract(word, addr[1:0], size, unsigned) returns the extended data.
  - It is instantiated twice: once on the store path, once on the load path.

## Test plan
- Word store then load:
  - sw 0x12345678 @0x10, then lw @0x10 → mem_w once at index 4.
  - Load rsp_rdata=0x12345678, rsp_err=0.
- Byte RMW:
  - Memory word 4 holds 0x12345678; sb 0xAB @0x12.
  - Sequence: mem_r cycle, then mem_w cycle with wdata 0x12AB5678. req_ready is low during RMW.
  - rsp_valid fires 2 cycles after acceptance.
- Extension, with word 4 = 0x12AB5678:
  - lb @0x12 → 0xFFFFFFAB
  - lbu @0x12 → 0x000000AB
  - lh @0x12 → 0x000012AB
  - sh 0x8001 @0x10 → word becomes 0x12AB8001; then lh @0x10 → 0xFFFF8001
- Errors: each of the following gives rsp_err=1 with no mem_r or mem_w:
  - lh @0x11
  - sw @0x12
  - lw @0x1000 (with ADDR_W=10)
  - req_size=11
- Reset mid-RMW:
  - Assert clr_n=0 during the RMW cycle of sb @0x20.
  - Required: mem_w drops without a clock edge; word 8 is unchanged; outputs are 0.
  - After release, req_ready=1.
- Back-to-back:
  - lw, sw, lb issued on consecutive cycles → three accepts on three consecutive edges.
  - rsp_valid high for 3 consecutive cycles with the correct data each cycle.
